// File: rtl/axil_reg_if_lite.sv
// axil_reg_if_lite
//   AXI-lite slave that turns each read or write into a strobe/acknowledge
//   register access. The write path and the read path are separate FSMs.
//   Each access has a timeout, so a register that never acks cannot hang
//   the bus; it gets a SLVERR response instead.
//
// Ports
//   clk, rst_n            : clock (rising edge), asynchronous active-low reset
//   s_axil_aw*/w*/b*      : AXI-lite write address, write data and write response
//   s_axil_ar*/r*         : AXI-lite read address and read data
//   reg_wr_*              : register write strobe interface (en held until ack/timeout)
//   reg_rd_*              : register read strobe interface (en held until ack/timeout)
//   reg_*_wait            : while high, the access timeout counter is frozen
module axil_reg_if_lite #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic [ADDR_WIDTH-1:0] reg_wr_addr,
  output logic [DATA_WIDTH-1:0] reg_wr_data,
  output logic [STRB_WIDTH-1:0] reg_wr_strb,
  output logic                  reg_wr_en,
  input  logic                  reg_wr_wait,
  input  logic                  reg_wr_ack,
  output logic [ADDR_WIDTH-1:0] reg_rd_addr,
  output logic                  reg_rd_en,
  input  logic [DATA_WIDTH-1:0] reg_rd_data,
  input  logic                  reg_rd_wait,
  input  logic                  reg_rd_ack
);

  localparam int                    CNT_WIDTH   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_LOAD    = CNT_WIDTH'(TIMEOUT - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK   = ~ADDR_WIDTH'(STRB_WIDTH - 1);
  localparam logic [1:0]            RESP_OKAY   = 2'b00;
  localparam logic [1:0]            RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_ACCESS, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ACCESS, R_RESP} r_state_t;

  w_state_t             w_state;
  r_state_t             r_state;
  logic [CNT_WIDTH-1:0] w_cnt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 wr_accept;
  logic                 rd_accept;

  // Protection bits carry no meaning for the register map.
  logic unused_prot;
  assign unused_prot = ^{s_axil_awprot, s_axil_arprot};

  // The readys are combinational from the valids in IDLE. They are gated
  // with rst_n so that they read 0 while reset is held. Address and data
  // are only ever accepted together.
  assign wr_accept      = (w_state == W_IDLE) & s_axil_awvalid & s_axil_wvalid & rst_n;
  assign rd_accept      = (r_state == R_IDLE) & s_axil_arvalid & rst_n;
  assign s_axil_awready = wr_accept;
  assign s_axil_wready  = wr_accept;
  assign s_axil_arready = rd_accept;

  // Write path. Ack has priority over the timeout, so an ack that lands on
  // the last counter cycle still gives OKAY. Wait freezes the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state       <= W_IDLE;
      w_cnt         <= '0;
      reg_wr_addr   <= '0;
      reg_wr_data   <= '0;
      reg_wr_strb   <= '0;
      reg_wr_en     <= 1'b0;
      s_axil_bvalid <= 1'b0;
      s_axil_bresp  <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (s_axil_awvalid && s_axil_wvalid) begin
            reg_wr_addr <= s_axil_awaddr & ADDR_MASK;
            reg_wr_data <= s_axil_wdata;
            reg_wr_strb <= s_axil_wstrb;
            w_cnt       <= CNT_LOAD;
            reg_wr_en   <= 1'b1;
            w_state     <= W_ACCESS;
          end
        end
        W_ACCESS: begin
          if (reg_wr_ack) begin
            reg_wr_en     <= 1'b0;
            s_axil_bresp  <= RESP_OKAY;
            s_axil_bvalid <= 1'b1;
            w_state       <= W_RESP;
          end else if (reg_wr_wait) begin
            w_cnt <= w_cnt;
          end else if (w_cnt == '0) begin
            reg_wr_en     <= 1'b0;
            s_axil_bresp  <= RESP_SLVERR;
            s_axil_bvalid <= 1'b1;
            w_state       <= W_RESP;
          end else begin
            w_cnt <= w_cnt - CNT_WIDTH'(1);
          end
        end
        W_RESP: begin
          if (s_axil_bready) begin
            s_axil_bvalid <= 1'b0;
            w_state       <= W_IDLE;
          end
        end
        default: begin
          reg_wr_en     <= 1'b0;
          s_axil_bvalid <= 1'b0;
          w_state       <= W_IDLE;
        end
      endcase
    end
  end

  // Read path, the same structure as the write path. A timed-out read
  // returns zero data so that stale register contents never leak out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= R_IDLE;
      r_cnt         <= '0;
      reg_rd_addr   <= '0;
      reg_rd_en     <= 1'b0;
      s_axil_rvalid <= 1'b0;
      s_axil_rresp  <= RESP_OKAY;
      s_axil_rdata  <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (s_axil_arvalid) begin
            reg_rd_addr <= s_axil_araddr & ADDR_MASK;
            r_cnt       <= CNT_LOAD;
            reg_rd_en   <= 1'b1;
            r_state     <= R_ACCESS;
          end
        end
        R_ACCESS: begin
          if (reg_rd_ack) begin
            reg_rd_en     <= 1'b0;
            s_axil_rdata  <= reg_rd_data;
            s_axil_rresp  <= RESP_OKAY;
            s_axil_rvalid <= 1'b1;
            r_state       <= R_RESP;
          end else if (reg_rd_wait) begin
            r_cnt <= r_cnt;
          end else if (r_cnt == '0) begin
            reg_rd_en     <= 1'b0;
            s_axil_rdata  <= '0;
            s_axil_rresp  <= RESP_SLVERR;
            s_axil_rvalid <= 1'b1;
            r_state       <= R_RESP;
          end else begin
            r_cnt <= r_cnt - CNT_WIDTH'(1);
          end
        end
        R_RESP: begin
          if (s_axil_rready) begin
            s_axil_rvalid <= 1'b0;
            r_state       <= R_IDLE;
          end
        end
        default: begin
          reg_rd_en     <= 1'b0;
          s_axil_rvalid <= 1'b0;
          r_state       <= R_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil_reg_if_lite.sv
// tb_axil_reg_if_lite
//   Self-checking bench for axil_reg_if_lite with the default parameters
//   (32-bit data, 16-bit address, TIMEOUT = 4). Cycle 0 is the handshake
//   cycle; later cycle numbers count from there.
module tb_axil_reg_if_lite;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] s_axil_awaddr;
  logic [2:0]  s_axil_awprot;
  logic        s_axil_awvalid;
  logic        s_axil_awready;
  logic [31:0] s_axil_wdata;
  logic [3:0]  s_axil_wstrb;
  logic        s_axil_wvalid;
  logic        s_axil_wready;
  logic [1:0]  s_axil_bresp;
  logic        s_axil_bvalid;
  logic        s_axil_bready;
  logic [15:0] s_axil_araddr;
  logic [2:0]  s_axil_arprot;
  logic        s_axil_arvalid;
  logic        s_axil_arready;
  logic [31:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic        s_axil_rvalid;
  logic        s_axil_rready;
  logic [15:0] reg_wr_addr;
  logic [31:0] reg_wr_data;
  logic [3:0]  reg_wr_strb;
  logic        reg_wr_en;
  logic        reg_wr_wait;
  logic        reg_wr_ack;
  logic [15:0] reg_rd_addr;
  logic        reg_rd_en;
  logic [31:0] reg_rd_data;
  logic        reg_rd_wait;
  logic        reg_rd_ack;

  axil_reg_if_lite #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .STRB_WIDTH(4), .TIMEOUT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
    .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
    .s_axil_bready(s_axil_bready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .reg_wr_strb(reg_wr_strb), .reg_wr_en(reg_wr_en),
    .reg_wr_wait(reg_wr_wait), .reg_wr_ack(reg_wr_ack),
    .reg_rd_addr(reg_rd_addr), .reg_rd_en(reg_rd_en),
    .reg_rd_data(reg_rd_data), .reg_rd_wait(reg_rd_wait),
    .reg_rd_ack(reg_rd_ack)
  );

  always #5 clk = ~clk;

  // One transaction: ack_cyc = 0 means no ack; wait is high in cycles
  // wait_lo..wait_hi; exp_cyc is the cycle in which the response is valid.
  typedef struct {
    bit          is_rd;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          ack_cyc;
    int          wait_lo;
    int          wait_hi;
    logic [15:0] exp_addr;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    int          exp_cyc;
  } vec_t;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  vec_t vecs[9];
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    exp_t got;
    int   en_cnt;
    int   resp_cyc;
    bit   stable;
    bit   seen;
    e.resp  = v.exp_resp;
    e.rdata = v.exp_rdata;
    e.cyc   = v.exp_cyc;
    sb_q.push_back(e);

    @(posedge clk); #1;
    if (v.is_rd) begin
      s_axil_araddr  = v.addr;
      s_axil_arvalid = 1'b1;
    end else begin
      s_axil_awaddr  = v.addr;
      s_axil_wdata   = v.data;
      s_axil_wstrb   = v.strb;
      s_axil_awvalid = 1'b1;
      s_axil_wvalid  = 1'b1;
    end
    @(negedge clk);
    checkOutput(v.is_rd ? "arready" : "awready_wready",
                32'(v.is_rd ? s_axil_arready : (s_axil_awready & s_axil_wready)), 32'd1);

    @(posedge clk); #1;
    s_axil_arvalid = 1'b0;
    s_axil_awvalid = 1'b0;
    s_axil_wvalid  = 1'b0;
    en_cnt   = 0;
    resp_cyc = 0;
    stable   = 1'b1;
    seen     = 1'b0;
    for (int c = 1; c <= 30 && !seen; c++) begin
      if (c > 1) begin
        @(posedge clk); #1;
      end
      if (v.is_rd) begin
        reg_rd_ack  = (c == v.ack_cyc);
        reg_rd_wait = (c >= v.wait_lo && c <= v.wait_hi);
        reg_rd_data = v.data;
      end else begin
        reg_wr_ack  = (c == v.ack_cyc);
        reg_wr_wait = (c >= v.wait_lo && c <= v.wait_hi);
      end
      @(negedge clk);
      if (v.is_rd ? reg_rd_en : reg_wr_en) begin
        en_cnt++;
        if (v.is_rd ? (reg_rd_addr !== v.exp_addr)
                    : (reg_wr_addr !== v.exp_addr || reg_wr_data !== v.data ||
                       reg_wr_strb !== v.strb))
          stable = 1'b0;
      end
      if (v.is_rd ? s_axil_rvalid : s_axil_bvalid) begin
        seen     = 1'b1;
        resp_cyc = c;
      end
    end
    reg_rd_ack  = 1'b0;
    reg_wr_ack  = 1'b0;
    reg_rd_wait = 1'b0;
    reg_wr_wait = 1'b0;

    got = sb_q.pop_front();
    if (!seen) begin
      checkOutput("response_timeout", 32'd0, 32'd1);
    end else begin
      checkOutput("resp_cycle", 32'(resp_cyc), 32'(got.cyc));
      checkOutput("resp", 32'(v.is_rd ? s_axil_rresp : s_axil_bresp), 32'(got.resp));
      if (v.is_rd) checkOutput("rdata", s_axil_rdata, got.rdata);
    end
    checkOutput("en_cycles", 32'(en_cnt), 32'(v.exp_cyc - 1));
    checkOutput("addr_data_stable", 32'(stable), 32'd1);

    @(posedge clk); #1;
    s_axil_bready = 1'b1;
    s_axil_rready = 1'b1;
    @(negedge clk);
    checkOutput("valid_held", 32'(v.is_rd ? s_axil_rvalid : s_axil_bvalid), 32'd1);
    @(posedge clk); #1;
    s_axil_bready = 1'b0;
    s_axil_rready = 1'b0;
    @(negedge clk);
    checkOutput("valid_dropped", 32'(v.is_rd ? s_axil_rvalid : s_axil_bvalid), 32'd0);
  endtask

  initial begin
    exp_t got;
    //           rd  addr      data          strb  ack wlo whi exp_addr  resp   rdata         cyc
    vecs[0] = '{1'b0, 16'h0013, 32'hDEADBEEF, 4'hF, 1, 0, -1, 16'h0010, 2'b00, 32'h0,        2};
    vecs[1] = '{1'b1, 16'h0024, 32'h12345678, 4'h0, 3, 0, -1, 16'h0024, 2'b00, 32'h12345678, 4};
    vecs[2] = '{1'b0, 16'h0100, 32'h11223344, 4'h3, 0, 0, -1, 16'h0100, 2'b10, 32'h0,        5};
    vecs[3] = '{1'b1, 16'h0031, 32'hCAFEF00D, 4'h0, 0, 0, -1, 16'h0030, 2'b10, 32'h0,        5};
    vecs[4] = '{1'b0, 16'h0042, 32'h0F0F0F0F, 4'h5, 7, 2,  5, 16'h0040, 2'b00, 32'h0,        8};
    vecs[5] = '{1'b0, 16'h0058, 32'h89ABCDEF, 4'h8, 4, 0, -1, 16'h0058, 2'b00, 32'h0,        5};
    vecs[6] = '{1'b1, 16'h0060, 32'h77777777, 4'h0, 0, 2,  3, 16'h0060, 2'b10, 32'h0,        7};
    vecs[7] = '{1'b1, 16'h007F, 32'hA5A5A5A5, 4'h0, 4, 0, -1, 16'h007C, 2'b00, 32'hA5A5A5A5, 5};
    vecs[8] = '{1'b0, 16'h0086, 32'h13572468, 4'hC, 0, 1,  1, 16'h0084, 2'b10, 32'h0,        6};

    rst_n          = 1'b0;
    s_axil_awaddr  = 16'h1234;
    s_axil_awprot  = 3'b000;
    s_axil_wdata   = 32'h0;
    s_axil_wstrb   = 4'hF;
    s_axil_araddr  = 16'h5678;
    s_axil_arprot  = 3'b000;
    s_axil_awvalid = 1'b1;
    s_axil_wvalid  = 1'b1;
    s_axil_arvalid = 1'b1;
    s_axil_bready  = 1'b0;
    s_axil_rready  = 1'b0;
    reg_wr_wait    = 1'b0;
    reg_wr_ack     = 1'b0;
    reg_rd_data    = 32'h0;
    reg_rd_wait    = 1'b0;
    reg_rd_ack     = 1'b0;

    // Reset state, with valids asserted to show the readys are gated.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_readys", 32'({s_axil_awready, s_axil_wready, s_axil_arready}), 32'd0);
    checkOutput("rst_valids", 32'({s_axil_bvalid, s_axil_rvalid}), 32'd0);
    checkOutput("rst_resps", 32'({s_axil_bresp, s_axil_rresp}), 32'd0);
    checkOutput("rst_rdata", s_axil_rdata, 32'd0);
    checkOutput("rst_en", 32'({reg_wr_en, reg_rd_en}), 32'd0);
    checkOutput("rst_wr_addr", 32'(reg_wr_addr), 32'd0);
    checkOutput("rst_wr_data", reg_wr_data, 32'd0);
    s_axil_awvalid = 1'b0;
    s_axil_wvalid  = 1'b0;
    s_axil_arvalid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Acks while idle must be ignored.
    reg_wr_ack = 1'b1;
    reg_rd_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reg_wr_ack = 1'b0;
    reg_rd_ack = 1'b0;
    @(negedge clk);
    checkOutput("idle_ack_ignored", 32'({s_axil_bvalid, s_axil_rvalid, reg_wr_en, reg_rd_en}), 32'd0);

    for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);

    // awvalid alone for 5 cycles, with a read running alongside.
    @(posedge clk); #1;
    s_axil_awaddr  = 16'h0200;
    s_axil_wdata   = 32'h600DCAFE;
    s_axil_wstrb   = 4'hF;
    s_axil_awvalid = 1'b1;
    s_axil_araddr  = 16'h0204;
    s_axil_arvalid = 1'b1;
    sb_q.push_back('{2'b00, 32'h0BADF00D, 2});
    @(negedge clk);
    checkOutput("aw_only_c0", 32'({s_axil_awready, s_axil_wready, s_axil_arready}), 32'b001);
    @(posedge clk); #1;
    s_axil_arvalid = 1'b0;
    reg_rd_ack     = 1'b1;
    reg_rd_data    = 32'h0BADF00D;
    @(negedge clk);
    checkOutput("aw_only_c1", 32'({s_axil_awready, reg_rd_en}), 32'b01);
    @(posedge clk); #1;
    reg_rd_ack    = 1'b0;
    s_axil_rready = 1'b1;
    @(negedge clk);
    got = sb_q.pop_front();
    checkOutput("conc_rvalid", 32'(s_axil_rvalid), 32'd1);
    checkOutput("conc_rdata", s_axil_rdata, got.rdata);
    checkOutput("conc_rresp_aw_only_c2", 32'({s_axil_rresp, s_axil_awready}), 32'({got.resp, 1'b0}));
    @(posedge clk); #1;
    s_axil_rready = 1'b0;
    @(negedge clk);
    checkOutput("aw_only_c3", 32'({s_axil_awready, s_axil_rvalid}), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("aw_only_c4", 32'(s_axil_awready), 32'd0);
    @(posedge clk); #1;
    s_axil_wvalid = 1'b1;
    @(negedge clk);
    checkOutput("aw_w_accept", 32'({s_axil_awready, s_axil_wready}), 32'b11);
    @(posedge clk); #1;
    s_axil_awvalid = 1'b0;
    s_axil_wvalid  = 1'b0;
    reg_wr_ack     = 1'b1;
    @(negedge clk);
    checkOutput("late_w_data", reg_wr_data, 32'h600DCAFE);

    // Response cycle with bready high and the next write already offered.
    @(posedge clk); #1;
    reg_wr_ack     = 1'b0;
    s_axil_bready  = 1'b1;
    s_axil_awaddr  = 16'h0302;
    s_axil_wdata   = 32'h55AA55AA;
    s_axil_awvalid = 1'b1;
    s_axil_wvalid  = 1'b1;
    @(negedge clk);
    checkOutput("late_w_bvalid_bresp", 32'({s_axil_bvalid, s_axil_bresp, s_axil_awready}), 32'b1000);
    @(posedge clk); #1;
    s_axil_bready = 1'b0;
    @(negedge clk);
    checkOutput("b2b_accept", 32'({s_axil_awready, s_axil_bvalid}), 32'b10);
    @(posedge clk); #1;
    s_axil_awvalid = 1'b0;
    s_axil_wvalid  = 1'b0;
    @(negedge clk);
    checkOutput("b2b_en_addr", 32'({reg_wr_en, reg_wr_addr}), 32'({1'b1, 16'h0300}));

    // Asynchronous reset while in W_ACCESS, bready low.
    #2;
    rst_n          = 1'b0;
    s_axil_awvalid = 1'b1;
    s_axil_wvalid  = 1'b1;
    s_axil_arvalid = 1'b1;
    #1;
    checkOutput("async_rst_drop",
                32'({reg_wr_en, reg_rd_en, s_axil_bvalid, s_axil_rvalid,
                     s_axil_awready, s_axil_wready, s_axil_arready}), 32'd0);
    @(posedge clk); #1;
    s_axil_awvalid = 1'b0;
    s_axil_wvalid  = 1'b0;
    s_axil_arvalid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(vecs[0]);

    checkOutput("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axil_reg_if_lite.md
# axil_reg_if_lite

Single-clock AXI-lite slave that converts AXI-lite read and write transactions into a simple strobe/acknowledge register-access interface. It sits directly downstream of the AXI-lite clock-domain crossing on its master side, in the register clock domain. It feeds the block's control/status register decode logic. Write and read paths are independent FSMs with a per-access timeout, so a missing register never hangs the bus.

## Interface

- DATA_WIDTH, 32, data bus width in bits
- ADDR_WIDTH, 16, address width in bits
- STRB_WIDTH, DATA_WIDTH/8, byte strobe width
- TIMEOUT, 4, maximum cycles an access waits for ack (must be ≥1)

Ports:

- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- s_axil_awaddr/awprot/awvalid  in  ADDR_WIDTH/3/1  write address; awprot ignored
- s_axil_awready  out  1
- s_axil_wdata/wstrb/wvalid  in  DATA_WIDTH/STRB_WIDTH/1
- s_axil_wready  out  1
- s_axil_bresp  out  2
- s_axil_bvalid  out  1
- s_axil_bready  in  1
- s_axil_araddr/arprot/arvalid  in  ADDR_WIDTH/3/1  read address; arprot ignored
- s_axil_arready  out  1
- s_axil_rdata  out  DATA_WIDTH
- s_axil_rresp  out  2
- s_axil_rvalid  out  1
- s_axil_rready  in  1
- reg_wr_addr  out  ADDR_WIDTH  word-aligned write address (low log2(STRB_WIDTH) bits zero)
- reg_wr_data  out  DATA_WIDTH
- reg_wr_strb  out  STRB_WIDTH
- reg_wr_en  out  1  write strobe, held until ack/timeout
- reg_wr_wait  in  1  freezes write timeout
- reg_wr_ack  in  1  write complete
- reg_rd_addr  out  ADDR_WIDTH  word-aligned read address
- reg_rd_en  out  1  read strobe, held until ack/timeout
- reg_rd_data  in  DATA_WIDTH  valid when reg_rd_ack high
- reg_rd_wait  in  1  freezes read timeout
- reg_rd_ack  in  1  read complete

## Operation

- Write FSM states: W_IDLE, W_ACCESS, W_RESP.
  - W_IDLE: awready = wready = awvalid & wvalid. Both channels are accepted in the same cycle, never separately.
  - On accept, register addr/data/strb, load counter with TIMEOUT-1, and go to W_ACCESS.
- W_ACCESS: reg_wr_en=1. Priority order:
  - ack → bresp=OKAY(00), go to W_RESP.
  - else wait → hold counter.
  - else counter==0 → bresp=SLVERR(10), go to W_RESP.
  - else counter−1.
- W_RESP: bvalid=1. On bready, go to W_IDLE.
- Read FSM (R_IDLE, R_ACCESS, R_RESP) mirrors the write FSM.
  - arready = arvalid in R_IDLE.
  - R_ACCESS drives reg_rd_en.
  - On ack, capture reg_rd_data into rdata with rresp=OKAY.
  - On timeout, rdata=0 and rresp=SLVERR.
  - R_RESP holds rvalid until rready.
- The two FSMs run concurrently. Simultaneous reg_wr_en and reg_rd_en is legal.
- Ack sampled while en is low is ignored.
- Ack in the cycle the counter reaches 0 wins: response is OKAY.
- Counter width is clog2(TIMEOUT+1). Counter never underflows.

## Timing

- Reset (rst_n low, async):
  - All FSMs return to IDLE.
  - All outputs are 0, including awready/wready/arready, which are gated by reset.
  - bresp/rresp = 00, rdata = 0.
- Reset mid-access drops the transaction: en and valid deassert immediately. Upstream must be reset together.
- Write latency:
  - Handshake at cycle 0; reg_wr_en high from cycle 1.
  - Ack at cycle k (≥1) gives bvalid at cycle k+1.
  - Minimum is bvalid at cycle 2.
- Timeout with wait low and no ack:
  - en is high for exactly TIMEOUT cycles (1..TIMEOUT).
  - SLVERR response valid at cycle TIMEOUT+1.
  - Each cycle with wait high extends this by one.
- Back-to-back throughput:
  - bready high with bvalid → W_IDLE next cycle.
  - Next accept is possible that cycle.
  - Minimum 3 cycles per transaction per path.
- reg_*_addr/data/strb are stable for the whole en assertion.
- Valid/ready outputs other than the IDLE-state readys are registered.

## Test plan

- Write 0xDEADBEEF, strb 0xF, addr 0x0013:
  - reg_wr_addr=0x0010, en at cycle 1, ack at cycle 1.
  - bvalid cycle 2, bresp=00.
- Read addr 0x0024; reg_rd_data=0x12345678 with ack at cycle 3:
  - rvalid at cycle 4, rdata=0x12345678, rresp=00.
- Write with no ack, wait low, TIMEOUT=4:
  - en high cycles 1–4; bvalid cycle 5, bresp=10.
  - Read timeout returns rdata=0, rresp=10.
- Wait high cycles 2–5, ack at cycle 7:
  - No timeout; OKAY response at cycle 8.
  - Ack on the final counter cycle also gives OKAY.
- awvalid without wvalid for 5 cycles:
  - awready stays 0; both accepted the cycle wvalid rises.
  - Concurrent read completes independently.
- rst_n low while in W_ACCESS with bready low:
  - en, bvalid and all readys drop asynchronously.
  - After release, a fresh write completes normally.
